mips_multicycle_core: RTL
=========================

# mips_multicycle_core

Multi-cycle MIPS32 integer core that replaces the single-cycle core. It uses one unified memory port with a ready/valid-style handshake, so instruction and data memories can have variable latency. The core is built around an explicit state machine and carries a retired-instruction counter. It sits between the testbench/SoC memory model and nothing else: all instruction and data traffic goes through the one port.

## Interface
- RESET_PC, default 32'h0000_0000: PC loaded on reset.
- CNT_W, default 32: width of the retired-instruction counter.

Clock and reset:
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst_b, input, 1: asynchronous, active-low reset.

Memory port:
- mem_req, output, 1: memory access request.
- mem_we, output, 1: write enable; valid only while mem_req=1.
- mem_addr, output, 32: byte address, word-aligned.
- mem_wdata, output, 32: store data, little-endian.
- mem_rdata, input, 32: read data; sampled when mem_req && mem_ready.
- mem_ready, input, 1: access complete this cycle.

Status:
- halted, output, 1: sticky; set on syscall or illegal.
- illegal, output, 1: sticky; set on unknown opcode/funct or misaligned lw/sw.
- instret, output, CNT_W: count of retired instructions. Wraps modulo 2^CNT_W.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready: latch IR and go to DECODE.
- DECODE
  - Read rs and rt into A and B.
  - Build the immediate: sign-extended, or zero-extended for andi/ori/xori.
  - syscall (op 0, funct 0x0C): go to HALT.
  - Illegal instruction: set illegal and go to HALT.
  - Otherwise go to EXEC.
- EXEC: compute ALU_out.
  - beq (0x04) / bne (0x05): on taken, pc = pc+4+(simm<<2), else pc+4. Retire, go to FETCH.
  - j (0x02): pc = {pc_plus4[31:28], idx, 2'b00}. Retire, go to FETCH.
  - jal (0x03): same target as j; also writes $31 = pc+4. Retire, go to FETCH.
  - jr (funct 0x08): pc = A. Retire, go to FETCH.
  - lw (0x23) / sw (0x2B): address = A+simm. If addr[1:0]≠0, set illegal and go to HALT with no access; else go to MEM.
  - All others go to WB.
- MEM
  - mem_req=1, mem_addr = address, mem_we = sw, mem_wdata = B.
  - On mem_ready: sw retires and goes to FETCH; lw latches MDR and goes to WB.
- WB
  - Destination: rd for R-type; rt for I-type and lw.
  - Write ALU_out (or MDR for lw).
  - Retire, pc += 4, go to FETCH.
- HALT: absorbing. No requests, no register writes, instret frozen.
- Retire means instret += 1. syscall and illegal instructions are not counted.
- ALU operations:
  - R-type funct: add 0x20 and addu 0x21 (no overflow trap), sub 0x22/subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A (signed), sltu 0x2B, sll 0x00/srl 0x02/sra 0x03 (by shamt).
  - I-type op: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B (compare against the sign-extended immediate, unsigned), andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F ({imm,16'h0}).
- Register file
  - 32×32.
  - $0 reads 0; writes to $0 are ignored.
  - All registers reset to 0.
- No delay slots. No exceptions other than halting.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, halted=0, illegal=0, instret=0, all registers 0, mem_we=0.
  - mem_req is 0 while rst_b=0.
  - mem_req goes to 1 in the first cycle after reset is released.
- Handshake
  - Once mem_req=1, mem_addr, mem_we and mem_wdata hold stable until the cycle with mem_ready=1.
  - mem_ready may be high in the same cycle req rises (zero-wait).
  - mem_ready while mem_req=0 is ignored.
- Latency in cycles with zero-wait memory. Each extra wait cycle adds 1 per access.
  - Branch/jump: 3.
  - R-type/I-type ALU: 4.
  - sw: 4.
  - lw: 5.
  - syscall: 2 cycles to reach HALT.
- halted and illegal assert on the clock edge that enters HALT.
- Reset asserted mid-access: the request drops immediately (asynchronously). The core restarts from FETCH at RESET_PC.

## Test plan
- Zero-wait ALU: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; syscall. Required: $3=2, instret=3, halted high 14 cycles after reset release.
- Load/store with wait states: ready delayed 3 cycles per access. sw $1,8($0) with $1=0xDEADBEEF, then lw $4,8($0). Required: write beat carries addr=8, we=1, wdata=0xDEADBEEF; $4=0xDEADBEEF; request signals stable during the wait cycles.
- Branches: loop with bne counting $5 from 0 to 4, then beq taken past a trap, then jal/jr round trip. Required: $5=4, $31 = jal address+4, final pc correct.
- Signed/unsigned: slt/sltu with 0xFFFFFFFF vs 1 gives 1/0. sra 0x80000000 by 4 gives 0xF8000000. lui 0x1234 gives 0x12340000. Write to $0 leaves $0 at 0.
- Illegal/misaligned: lw at address 6. Required: no mem_req for the data access, illegal=1, halted=1, instret unchanged.
- Reset mid-fetch: drop rst_b while mem_req=1 and ready=0. Required: mem_req=0 immediately; after release, the first fetch address = RESET_PC and instret=0.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port with a ready/valid-style handshake.
interface mips_multicycle_core_if;
  localparam int unsigned XLEN = 32;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  // Core side: issues requests, consumes read data and completion.
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  // Memory side: serves requests.
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 integer core on a single variable-latency memory port.
// Walks FETCH/DECODE/EXEC/MEM/WB per instruction; HALT is absorbing.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_b,
  mips_multicycle_core_if.master   mem,
  output logic                     halted,
  output logic                     illegal,
  output logic [CNT_W-1:0]         instret
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned RIDX  = 5;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nx;

  logic [XLEN-1:0] pc, ir, a, b, alu_out, mdr;
  logic [XLEN-1:0] regs [NREG];

  // Instruction fields
  logic [5:0]      op, funct;
  logic [RIDX-1:0] rs, rt, rd, shamt;
  logic [15:0]     imm16;
  logic [25:0]     idx;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm16 = ir[15:0];
  assign idx   = ir[25:0];

  logic            legal_c;
  logic [XLEN-1:0] imm_ext_c, alu_res_c, pc_plus4_c, br_target_c, j_target_c;
  logic            br_taken_c;

  // Control outputs from the FSM
  logic            req_c, we_c;
  logic [XLEN-1:0] addr_c, wdata_c, pc_nx_c, rf_wdata_c;
  logic [RIDX-1:0] rf_waddr_c;
  logic            ir_ld_c, ab_ld_c, alu_ld_c, mdr_ld_c, pc_ld_c, rf_we_c;
  logic            retire_c, set_halt_c, set_illegal_c;

  // Recognise every encoding the core implements (syscall handled separately)
  always_comb begin
    legal_c = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_JR,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:  legal_c = 1'b1;
          default:          legal_c = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LW, OP_SW:       legal_c = 1'b1;
      default:            legal_c = 1'b0;
    endcase
  end

  // Immediate: logical ops zero-extend, everything else sign-extends
  always_comb begin
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
      imm_ext_c = {16'h0000, imm16};
    end else begin
      imm_ext_c = {{16{imm16[15]}}, imm16};
    end
  end

  // Next-PC candidates
  always_comb begin
    pc_plus4_c  = pc + 32'd4;
    br_target_c = pc_plus4_c + {imm_ext_c[29:0], 2'b00};
    j_target_c  = {pc_plus4_c[31:28], idx, 2'b00};
    br_taken_c  = (op == OP_BEQ) ? (a == b) : (a != b);
  end

  // ALU: R-type selects by funct, I-type by opcode; lw/sw use the add path
  always_comb begin
    alu_res_c = '0;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_res_c = a + b;
        FN_SUB, FN_SUBU: alu_res_c = a - b;
        FN_AND:          alu_res_c = a & b;
        FN_OR:           alu_res_c = a | b;
        FN_XOR:          alu_res_c = a ^ b;
        FN_NOR:          alu_res_c = ~(a | b);
        FN_SLT:          alu_res_c = {31'd0, ($signed(a) < $signed(b))};
        FN_SLTU:         alu_res_c = {31'd0, (a < b)};
        FN_SLL:          alu_res_c = b << shamt;
        FN_SRL:          alu_res_c = b >> shamt;
        FN_SRA:          alu_res_c = 32'($signed(b) >>> shamt);
        default:         alu_res_c = '0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ADDIU,
        OP_LW, OP_SW:    alu_res_c = a + imm_ext_c;
        OP_SLTI:         alu_res_c = {31'd0, ($signed(a) < $signed(imm_ext_c))};
        OP_SLTIU:        alu_res_c = {31'd0, (a < imm_ext_c)};
        OP_ANDI:         alu_res_c = a & imm_ext_c;
        OP_ORI:          alu_res_c = a | imm_ext_c;
        OP_XORI:         alu_res_c = a ^ imm_ext_c;
        OP_LUI:          alu_res_c = {imm16, 16'h0000};
        default:         alu_res_c = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state control
  always_comb begin
    state_nx      = state;
    req_c         = 1'b0;
    we_c          = 1'b0;
    addr_c        = pc;
    wdata_c       = b;
    ir_ld_c       = 1'b0;
    ab_ld_c       = 1'b0;
    alu_ld_c      = 1'b0;
    mdr_ld_c      = 1'b0;
    pc_ld_c       = 1'b0;
    pc_nx_c       = pc_plus4_c;
    rf_we_c       = 1'b0;
    rf_waddr_c    = rd;
    rf_wdata_c    = alu_out;
    retire_c      = 1'b0;
    set_halt_c    = 1'b0;
    set_illegal_c = 1'b0;

    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_ld_c  = 1'b1;
          state_nx = S_DECODE;
        end
      end

      S_DECODE: begin
        ab_ld_c = 1'b1;
        if (op == OP_RTYPE && funct == FN_SYSCALL) begin
          set_halt_c = 1'b1;
          state_nx   = S_HALT;
        end else if (!legal_c) begin
          set_halt_c    = 1'b1;
          set_illegal_c = 1'b1;
          state_nx      = S_HALT;
        end else begin
          state_nx = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_BEQ, OP_BNE: begin
            pc_ld_c  = 1'b1;
            pc_nx_c  = br_taken_c ? br_target_c : pc_plus4_c;
            retire_c = 1'b1;
            state_nx = S_FETCH;
          end
          OP_J: begin
            pc_ld_c  = 1'b1;
            pc_nx_c  = j_target_c;
            retire_c = 1'b1;
            state_nx = S_FETCH;
          end
          OP_JAL: begin
            pc_ld_c    = 1'b1;
            pc_nx_c    = j_target_c;
            rf_we_c    = 1'b1;
            rf_waddr_c = 5'd31;
            rf_wdata_c = pc_plus4_c;
            retire_c   = 1'b1;
            state_nx   = S_FETCH;
          end
          OP_LW, OP_SW: begin
            // Misaligned word access halts before touching memory
            if (alu_res_c[1:0] != 2'b00) begin
              set_halt_c    = 1'b1;
              set_illegal_c = 1'b1;
              state_nx      = S_HALT;
            end else begin
              alu_ld_c = 1'b1;
              state_nx = S_MEM;
            end
          end
          OP_RTYPE: begin
            if (funct == FN_JR) begin
              pc_ld_c  = 1'b1;
              pc_nx_c  = a;
              retire_c = 1'b1;
              state_nx = S_FETCH;
            end else begin
              alu_ld_c = 1'b1;
              state_nx = S_WB;
            end
          end
          default: begin
            alu_ld_c = 1'b1;
            state_nx = S_WB;
          end
        endcase
      end

      S_MEM: begin
        // Address comes from the latched ALU result so it holds during waits
        req_c   = 1'b1;
        addr_c  = alu_out;
        we_c    = (op == OP_SW);
        wdata_c = b;
        if (mem.mem_ready) begin
          if (op == OP_SW) begin
            pc_ld_c  = 1'b1;
            retire_c = 1'b1;
            state_nx = S_FETCH;
          end else begin
            mdr_ld_c = 1'b1;
            state_nx = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = (op == OP_RTYPE) ? rd : rt;
        rf_wdata_c = (op == OP_LW) ? mdr : alu_out;
        pc_ld_c    = 1'b1;
        retire_c   = 1'b1;
        state_nx   = S_FETCH;
      end

      S_HALT: begin
        state_nx = S_HALT;
      end

      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

  // Request is gated by reset so it drops the moment reset asserts
  assign mem.mem_req   = req_c & rst_b;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

  // Datapath registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (pc_ld_c)  pc      <= pc_nx_c;
      if (ir_ld_c)  ir      <= mem.mem_rdata;
      if (ab_ld_c) begin
        a <= regs[rs];
        b <= regs[rt];
      end
      if (alu_ld_c) alu_out <= alu_res_c;
      if (mdr_ld_c) mdr     <= mem.mem_rdata;
    end
  end

  // Register file; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we_c && (rf_waddr_c != 5'd0)) begin
      regs[rf_waddr_c] <= rf_wdata_c;
    end
  end

  // Sticky status flags and retired-instruction counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      halted  <= 1'b0;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      if (set_halt_c)    halted  <= 1'b1;
      if (set_illegal_c) illegal <= 1'b1;
      if (retire_c)      instret <= instret + CNT_W'(1);
    end
  end

endmodule
